// File: rtl/counter_ctrl_pkg.sv
// Shared types for the counter command controller: opcodes, FSM states and
// the cnt_mode encodings understood by the existing counter.
package counter_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_UP   = 2'b01,
    OP_DOWN = 2'b10,
    OP_GOTO = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_DONE = 2'b10
  } state_e;

  localparam logic [1:0] MODE_HOLD = 2'b10;  // load cnt_in == cnt_q
  localparam logic [1:0] MODE_LOAD = 2'b10;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b00;

  // UP/DOWN are the only ops whose EXEC length comes from the len field.
  function automatic logic is_count(op_e op);
    return (op == OP_UP) || (op == OP_DOWN);
  endfunction

endpackage

// File: rtl/counter_if.sv
// Signal bundle between the controller and the existing counter, so the
// two can sit side by side without touching the counter itself.
interface counter_if #(
  parameter int BIT_WIDTH = 8
);
  logic [BIT_WIDTH-1:0] cnt_q;
  logic [BIT_WIDTH-1:0] cnt_in;
  logic [1:0]           cnt_mode;

  modport ctrl    (input cnt_q,  output cnt_in, output cnt_mode);
  modport counter (input cnt_in, input cnt_mode, output cnt_q);
endinterface

// File: rtl/counter_cmd_fifo.sv
// Synchronous command queue with registered storage, a one-cycle flush and
// full/empty flags derived from wrap-bit pointers.
module counter_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW:0]                 wr_ptr, rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/counter_ctrl.sv
// Sequences queued LOAD/UP/DOWN/GOTO commands onto an external counter,
// one at a time in acceptance order, with a done pulse per command.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int BIT_WIDTH  = 8,
  parameter int LEN_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  input  logic [1:0]           cmd_op,
  input  logic [BIT_WIDTH-1:0] cmd_value,
  input  logic [LEN_WIDTH-1:0] cmd_len,
  output logic                 cmd_ready,
  input  logic                 abort,
  input  logic [BIT_WIDTH-1:0] cnt_q,
  output logic [BIT_WIDTH-1:0] cnt_in,
  output logic [1:0]           cnt_mode,
  output logic                 busy,
  output logic                 done
);

  typedef struct packed {
    op_e                  op;
    logic [BIT_WIDTH-1:0] value;
    logic [LEN_WIDTH-1:0] len;
  } cmd_t;

  cmd_t   wr_cmd, head, cur;
  state_e state, state_nxt;
  logic   full, empty, push, pop;

  // Ready reflects the pre-pop fill level, so a full queue never takes a
  // push even in a cycle where the head is popped.
  assign cmd_ready = !full && !abort;
  assign push      = cmd_valid && cmd_ready && !rst;
  assign pop       = (state == S_IDLE) && !empty && !abort;

  assign wr_cmd.op    = op_e'(cmd_op);
  assign wr_cmd.value = cmd_value;
  assign wr_cmd.len   = cmd_len;

  counter_cmd_fifo #(
    .WIDTH ($bits(cmd_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (abort),
    .push  (push),
    .wdata (wr_cmd),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // cur.len doubles as the remaining-cycle counter for UP/DOWN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cur   <= '0;
    end else if (abort) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
      if (pop) cur <= head;
      else if (state == S_EXEC && cur.len != '0) cur.len <= cur.len - 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (pop) state_nxt = (is_count(head.op) && head.len == '0) ? S_DONE : S_EXEC;
      end
      S_EXEC: begin
        case (cur.op)
          OP_LOAD: state_nxt = S_DONE;
          OP_UP,
          OP_DOWN: if (cur.len <= LEN_WIDTH'(1)) state_nxt = S_DONE;
          OP_GOTO: if (cnt_q == cur.value) state_nxt = S_DONE;
        endcase
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_mode = MODE_HOLD;
    cnt_in   = cnt_q;
    if (state == S_EXEC) begin
      case (cur.op)
        OP_LOAD: begin
          cnt_mode = MODE_LOAD;
          cnt_in   = cur.value;
        end
        OP_UP:   cnt_mode = MODE_UP;
        OP_DOWN: cnt_mode = MODE_DOWN;
        OP_GOTO: begin
          if (cnt_q < cur.value)      cnt_mode = MODE_UP;
          else if (cnt_q > cur.value) cnt_mode = MODE_DOWN;
        end
      endcase
    end
  end

  assign done = (state == S_DONE);
  assign busy = (state != S_IDLE) || !empty;

endmodule

// File: tb/tb_counter_ctrl.sv
// Randomized and directed bench for counter_ctrl driving a behavioural
// counter; completed commands are checked against an arithmetic model.
module tb_counter_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_value = 8'd0;
  logic [7:0] cmd_len = 8'd0;
  logic       cmd_ready;
  logic       abort = 1'b0;
  logic [7:0] cnt = 8'd0;
  logic [7:0] cnt_in;
  logic [1:0] cnt_mode;
  logic       busy;
  logic       done;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {int op; int value; int len;} cmd_s;
  typedef struct {int cnt; int cyc;} ev_s;

  cmd_s exp_cmds[$];
  ev_s  done_log[$];
  int   busy_cyc = 0;
  int   model_cnt = 0;

  counter_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_value (cmd_value),
    .cmd_len   (cmd_len),
    .cmd_ready (cmd_ready),
    .abort     (abort),
    .cnt_q     (cnt),
    .cnt_in    (cnt_in),
    .cnt_mode  (cnt_mode),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // The existing counter, modelled behaviourally.
  always @(posedge clk) begin
    case (cnt_mode)
      2'b10:   cnt <= cnt_in;
      2'b01:   cnt <= cnt + 8'd1;
      2'b00:   cnt <= cnt - 8'd1;
      default: cnt <= cnt;
    endcase
  end

  // Log each done pulse with the counter value and busy cycles spent on it.
  always @(negedge clk) begin
    if (rst || abort) busy_cyc <= 0;
    else if (done) begin
      done_log.push_back('{int'(cnt), busy_cyc});
      busy_cyc <= 0;
    end else if (busy) busy_cyc <= busy_cyc + 1;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: result and EXEC cycle count of one command from a start value.
  function automatic void model_exec(input cmd_s c, input int start, output int fin, output int cyc);
    case (c.op)
      0: begin fin = c.value; cyc = 1; end
      1: begin fin = (start + c.len) % 256; cyc = c.len; end
      2: begin fin = (start - c.len + 256) % 256; cyc = c.len; end
      default: begin
        fin = c.value;
        cyc = ((c.value > start) ? c.value - start : start - c.value) + 1;
      end
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Offer one command starting now; returns after the accepting edge.
  task automatic push(input int op, input int val, input int len, output int stalls);
    cmd_valid = 1'b1;
    cmd_op    = 2'(op);
    cmd_value = 8'(val);
    cmd_len   = 8'(len);
    #1;
    stalls = 0;
    while (!cmd_ready && stalls < 1000) begin
      step();
      stalls++;
    end
    step();
    cmd_valid = 1'b0;
    exp_cmds.push_back('{op, val, len});
  endtask

  task automatic wait_idle(input string name, input int budget);
    int i = 0;
    while (busy !== 1'b0 && i < budget) begin
      step();
      i++;
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle_timeout busy=%b after %0d cycles", name, busy, i);
    end
  endtask

  task automatic wait_done_count(input string name, input int n);
    int i = 0;
    while (done_log.size() < n && i < 2000) begin
      step();
      i++;
    end
    n_cmp++;
    if (done_log.size() < n) begin
      n_fail++;
      $display("FAIL %s done_wait got %0d want %0d", name, done_log.size(), n);
    end
  endtask

  task automatic check_done(input string name);
    int e, c, n;
    n_cmp++;
    if (done_log.size() != exp_cmds.size()) begin
      n_fail++;
      $display("FAIL %s done_count got %0d want %0d", name, done_log.size(), exp_cmds.size());
    end
    n = (done_log.size() < exp_cmds.size()) ? done_log.size() : exp_cmds.size();
    for (int i = 0; i < n; i++) begin
      model_exec(exp_cmds[i], model_cnt, e, c);
      n_cmp++;
      if (done_log[i].cnt != e) begin
        n_fail++;
        $display("FAIL %s cmd%0d counter got %0d want %0d", name, i, done_log[i].cnt, e);
      end
      n_cmp++;
      if (done_log[i].cyc != c + 1) begin
        n_fail++;
        $display("FAIL %s cmd%0d busy_cycles got %0d want %0d", name, i, done_log[i].cyc, c + 1);
      end
      model_cnt = e;
    end
    done_log.delete();
    exp_cmds.delete();
  endtask

  task automatic test_reset();
    repeat (3) step();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset done got %b want 0", done); end
    n_cmp++; if (cnt_mode !== 2'b10) begin n_fail++; $display("FAIL reset cnt_mode got %b want 10", cnt_mode); end
    n_cmp++; if (cnt_in !== cnt) begin n_fail++; $display("FAIL reset cnt_in got %0d want %0d", cnt_in, cnt); end
    rst = 1'b0;
    #1;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset cmd_ready got %b want 1", cmd_ready); end
    step();
  endtask

  task automatic test_load_up();
    int s;
    push(0, 5, 0, s);
    push(1, 0, 3, s);
    wait_idle("load_up", 200);
    n_cmp++; if (cnt !== 8'd8) begin n_fail++; $display("FAIL load_up final got %0d want 8", cnt); end
    check_done("load_up");
  endtask

  task automatic test_wrap();
    int s;
    push(0, 250, 0, s);
    push(1, 0, 10, s);
    wait_idle("wrap", 200);
    n_cmp++; if (cnt !== 8'd4) begin n_fail++; $display("FAIL wrap final got %0d want 4", cnt); end
    check_done("wrap");
  endtask

  task automatic test_goto();
    int s;
    push(0, 20, 0, s);
    push(3, 12, 0, s);
    push(3, 12, 0, s);
    push(3, 200, 0, s);
    push(2, 0, 0, s);
    wait_idle("goto", 2000);
    n_cmp++; if (cnt !== 8'd200) begin n_fail++; $display("FAIL goto final got %0d want 200", cnt); end
    check_done("goto");
  endtask

  task automatic test_back_to_back();
    int s;
    int vals[5] = '{7, 0, 0, 15, 33};
    int ops[5]  = '{0, 1, 2, 3, 0};
    int lens[5] = '{0, 4, 2, 0, 0};
    push(1, 0, 20, s);
    step();
    for (int i = 0; i < 5; i++) begin
      push(ops[i], vals[i], lens[i], s);
      n_cmp++;
      if ((i < 4 && s != 0) || (i == 4 && s == 0)) begin
        n_fail++;
        $display("FAIL back_to_back stall%0d got %0d want %s", i, s, (i < 4) ? "0" : ">0");
      end
    end
    wait_idle("back_to_back", 500);
    check_done("back_to_back");
  endtask

  task automatic test_random();
    int s;
    for (int i = 0; i < 20; i++) begin
      push($urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 6), s);
      repeat ($urandom_range(0, 3)) step();
    end
    wait_idle("random", 20000);
    check_done("random");
  endtask

  task automatic test_abort();
    int s;
    logic [7:0] held;
    push(0, 100, 0, s);
    push(1, 0, 50, s);
    push(0, 1, 0, s);
    push(0, 2, 0, s);
    wait_done_count("abort", 1);
    repeat (10) step();
    abort = 1'b1;
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_value = 8'd77;
    #1;
    n_cmp++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL abort cmd_ready got %b want 0", cmd_ready); end
    step();
    abort = 1'b0;
    cmd_valid = 1'b0;
    held = cnt;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort busy got %b want 0", busy); end
    repeat (6) step();
    n_cmp++; if (cnt !== held) begin n_fail++; $display("FAIL abort hold got %0d want %0d", cnt, held); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort busy_later got %b want 0", busy); end
    while (exp_cmds.size() > 1) void'(exp_cmds.pop_back());
    check_done("abort");
    model_cnt = cnt;
  endtask

  task automatic test_rst_mid_goto();
    int s;
    push(0, 0, 0, s);
    push(3, 200, 0, s);
    wait_done_count("rst_goto", 1);
    repeat (20) step();
    rst = 1'b1;
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_value = 8'd5;
    step();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_goto busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_goto done got %b want 0", done); end
    n_cmp++; if (cnt_mode !== 2'b10) begin n_fail++; $display("FAIL rst_goto cnt_mode got %b want 10", cnt_mode); end
    step();
    rst = 1'b0;
    cmd_valid = 1'b0;
    #1;
    n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_goto cmd_ready got %b want 1", cmd_ready); end
    repeat (5) step();
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_goto busy_later got %b want 0", busy); end
    n_cmp++; if (cnt_mode !== 2'b10) begin n_fail++; $display("FAIL rst_goto mode_later got %b want 10", cnt_mode); end
    while (exp_cmds.size() > 1) void'(exp_cmds.pop_back());
    check_done("rst_goto");
    model_cnt = cnt;
  endtask

  initial begin
    step();
    test_reset();
    test_load_up();
    test_wrap();
    test_goto();
    test_back_to_back();
    test_random();
    test_abort();
    test_rst_mid_goto();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
